// File: rtl/regfile_wb_scheduler_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler_if
//
// Bundles the signals between the pipeline / MDU side and the register-file
// write-port scheduler.
//   master : pipeline writeback, MDU issue/result, decode source registers
//            (drives requests, observes ready/hazards/write port)
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface regfile_wb_scheduler_if;
    // Pipeline writeback
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    // MDU issue (scoreboard set) and result stream
    logic        mdu_issue_valid;
    logic [4:0]  mdu_issue_rd;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    // Decode hazard lookup
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard_rs1;
    logic        hazard_rs2;
    // Pipeline flow control and status
    logic        wb_stall_req;
    logic        protocol_err;
    // Register-file write port
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    modport master (
        output wb_valid, wb_rd, wb_data,
        output mdu_issue_valid, mdu_issue_rd,
        output mdu_valid, mdu_rd, mdu_data,
        output rs1, rs2,
        input  mdu_ready, hazard_rs1, hazard_rs2,
        input  wb_stall_req, protocol_err,
        input  rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data,
        input  mdu_issue_valid, mdu_issue_rd,
        input  mdu_valid, mdu_rd, mdu_data,
        input  rs1, rs2,
        output mdu_ready, hazard_rs1, hazard_rs2,
        output wb_stall_req, protocol_err,
        output rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler
//
// Arbitrates the single register-file write port between the in-order
// writeback stage and a long-latency MDU. MDU results are buffered in a small
// FIFO; a per-register busy scoreboard lets decode see RAW hazards on pending
// MDU results. If the MDU is denied the port for STARVE_LIMIT consecutive
// cycles, a WB stall is requested so the FIFO can drain.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   bus        regfile_wb_scheduler_if.slave (WB, MDU, decode, write port)
//   perf_mdu_grants / perf_stall_reqs (16-bit saturating counters)
//              present only when RF_SCHED_PERF_EN is defined
//
// Parameters:
//   FIFO_DEPTH    MDU result buffer entries (power of 2, >= 2)
//   STARVE_LIMIT  denied MDU cycles before a WB stall is requested (1..15)
// ---------------------------------------------------------------------------
module regfile_wb_scheduler #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_wb_scheduler_if.slave   bus
`ifdef RF_SCHED_PERF_EN
    ,
    output logic [15:0]             perf_mdu_grants,
    output logic [15:0]             perf_stall_reqs
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // FIFO storage and state
    logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   busy_q, busy_d;
    logic [3:0]    starve_q, starve_d;
    logic          stall_q, stall_d;
    logic          perr_q, perr_d;

    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_waddr_q, rf_waddr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;

    logic          empty, full, wb_eff, push, grant_mdu, grant_wb;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign wb_eff    = bus.wb_valid && (bus.wb_rd != 5'd0);
    // Ready comes from registered fullness only: a pop in the same cycle
    // does not let a held MDU result in until the next cycle.
    assign push      = bus.mdu_valid && !full;
    // While a stall is requested the MDU wins even over a (protocol-violating) WB.
    assign grant_mdu = !empty && (stall_q || !wb_eff);
    assign grant_wb  = wb_eff && !grant_mdu;
    assign head_rd   = fifo_rd_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    assign count_d = count_q + CW'(push) - CW'(grant_mdu);

    always_comb begin
        starve_d = starve_q;
        if (empty || grant_mdu) begin
            starve_d = 4'd0;
        end else if (starve_q < 4'(STARVE_LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Asserts on the edge where the counter reaches the limit; once up it
    // holds until the MDU has been granted (grant also clears starve_d).
    assign stall_d = (stall_q && !grant_mdu) || (starve_d == 4'(STARVE_LIMIT));

    assign perr_d = perr_q || (bus.wb_valid && stall_q);

    always_comb begin
        busy_d = busy_q;
        if (grant_mdu) begin
            busy_d[head_rd] = 1'b0;
        end
        // Issue is applied after the clear so a same-cycle set wins.
        if (bus.mdu_issue_valid) begin
            busy_d[bus.mdu_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = 5'd0;
        rf_wdata_d = 32'd0;
        if (grant_mdu) begin
            // An MDU result targeting x0 is popped without writing.
            rf_we_d    = (head_rd != 5'd0);
            rf_waddr_d = head_rd;
            rf_wdata_d = head_data;
        end else if (grant_wb) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.wb_rd;
            rf_wdata_d = bus.wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            busy_q     <= '0;
            starve_q   <= 4'd0;
            stall_q    <= 1'b0;
            perr_q     <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (grant_mdu) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q    <= count_d;
            busy_q     <= busy_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
            perr_q     <= perr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= bus.mdu_rd;
            fifo_data_q[wr_ptr_q] <= bus.mdu_data;
        end
    end

`ifdef RF_SCHED_PERF_EN
    logic [15:0] perf_grants_q, perf_stalls_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_grants_q <= 16'd0;
            perf_stalls_q <= 16'd0;
        end else begin
            if (grant_mdu && (perf_grants_q != 16'hFFFF)) begin
                perf_grants_q <= perf_grants_q + 16'd1;
            end
            if (stall_d && !stall_q && (perf_stalls_q != 16'hFFFF)) begin
                perf_stalls_q <= perf_stalls_q + 16'd1;
            end
        end
    end

    assign perf_mdu_grants = perf_grants_q;
    assign perf_stall_reqs = perf_stalls_q;
`endif

    assign bus.mdu_ready    = !full;
    assign bus.hazard_rs1   = busy_q[bus.rs1];
    assign bus.hazard_rs2   = busy_q[bus.rs2];
    assign bus.wb_stall_req = stall_q;
    assign bus.protocol_err = perr_q;
    assign bus.rf_we        = rf_we_q;
    assign bus.rf_waddr     = rf_waddr_q;
    assign bus.rf_wdata     = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_scheduler
//
// Directed bench for regfile_wb_scheduler (FIFO_DEPTH=2, STARVE_LIMIT=4):
// a vector table for plain WB writes plus hand-written multi-cycle sequences
// for MDU writeback, starvation stall, rd=0 handling, full FIFO, protocol
// error and mid-burst reset.
// ---------------------------------------------------------------------------
module tb_regfile_wb_scheduler;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    regfile_wb_scheduler_if bus ();

`ifdef RF_SCHED_PERF_EN
    logic [15:0] perf_mdu_grants;
    logic [15:0] perf_stall_reqs;
`endif

    regfile_wb_scheduler #(
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef RF_SCHED_PERF_EN
        ,
        .perf_mdu_grants (perf_mdu_grants),
        .perf_stall_reqs (perf_stall_reqs)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    // Write-port monitor (samples mid-cycle)
    logic        cap_en     = 1'b0;
    logic        x0_written = 1'b0;
    logic [4:0]  cap_rd   [$];
    logic [31:0] cap_data [$];

    always @(negedge clk) begin
        if (bus.rf_we && bus.rf_waddr == 5'd0) x0_written = 1'b1;
        if (cap_en && bus.rf_we && bus.rf_waddr != 5'd3) begin
            cap_rd.push_back(bus.rf_waddr);
            cap_data.push_back(bus.rf_wdata);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        wb_valid;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } wb_vec_t;

    wb_vec_t vecs [6];

    logic [4:0]  pend_rd   [3];
    logic [31:0] pend_data [3];

    initial begin
        int idx;
        int bad;

        vecs[0] = '{1'b1, 5'd5,  32'hA5A5_A5A5, 1'b1, 5'd5,  32'hA5A5_A5A5};
        vecs[1] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF};
        vecs[2] = '{1'b0, 5'd7,  32'h1111_1111, 1'b0, 5'd0,  32'h0};
        vecs[3] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0};
        vecs[4] = '{1'b1, 5'd1,  32'h0000_0001, 1'b1, 5'd1,  32'h0000_0001};
        vecs[5] = '{1'b1, 5'd17, 32'h1234_5678, 1'b1, 5'd17, 32'h1234_5678};

        bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
        bus.mdu_issue_valid = 0; bus.mdu_issue_rd = 0;
        bus.mdu_valid = 0; bus.mdu_rd = 0; bus.mdu_data = 0;
        bus.rs1 = 0; bus.rs2 = 0;
        reset = 1'b1;
        repeat (2) tick();

        // Reset state
        chk("rst_rf_we",    {31'd0, bus.rf_we},        32'd0);
        chk("rst_rf_waddr", {27'd0, bus.rf_waddr},     32'd0);
        chk("rst_rf_wdata", bus.rf_wdata,              32'd0);
        chk("rst_stall",    {31'd0, bus.wb_stall_req}, 32'd0);
        chk("rst_perr",     {31'd0, bus.protocol_err}, 32'd0);
        chk("rst_ready",    {31'd0, bus.mdu_ready},    32'd1);
`ifdef RF_SCHED_PERF_EN
        chk("rst_perf_g",   {16'd0, perf_mdu_grants},  32'd0);
`endif
        reset = 1'b0;
        tick();

        // Table-driven plain WB writes, idle MDU
        for (int i = 0; i < 6; i++) begin
            bus.wb_valid = vecs[i].wb_valid;
            bus.wb_rd    = vecs[i].wb_rd;
            bus.wb_data  = vecs[i].wb_data;
            tick();
            chk($sformatf("vec%0d_we", i), {31'd0, bus.rf_we}, {31'd0, vecs[i].exp_we});
            if (vecs[i].exp_we) begin
                chk($sformatf("vec%0d_addr", i), {27'd0, bus.rf_waddr}, {27'd0, vecs[i].exp_addr});
                chk($sformatf("vec%0d_data", i), bus.rf_wdata, vecs[i].exp_data);
            end
        end
        bus.wb_valid = 0;
        tick();

        // MDU issue rd=7, hazard, result written two cycles after push
        bus.mdu_issue_valid = 1; bus.mdu_issue_rd = 5'd7;
        tick();
        bus.mdu_issue_valid = 0;
        bus.rs1 = 5'd7; bus.rs2 = 5'd7;
        #1;
        chk("haz_rs1_set", {31'd0, bus.hazard_rs1}, 32'd1);
        chk("haz_rs2_set", {31'd0, bus.hazard_rs2}, 32'd1);
        bus.mdu_valid = 1; bus.mdu_rd = 5'd7; bus.mdu_data = 32'h1234_5678;
        tick();
        bus.mdu_valid = 0;
        chk("mdu7_not_yet", {31'd0, bus.rf_we}, 32'd0);
        tick();
        chk("mdu7_we",   {31'd0, bus.rf_we},    32'd1);
        chk("mdu7_addr", {27'd0, bus.rf_waddr}, 32'd7);
        chk("mdu7_data", bus.rf_wdata,          32'h1234_5678);
        chk("haz_rs1_clr", {31'd0, bus.hazard_rs1}, 32'd0);
        bus.rs1 = 0; bus.rs2 = 0;
        tick();

        // Starvation: continuous WB rd=3, one MDU entry rd=9
        bus.wb_valid = 1; bus.wb_rd = 5'd3; bus.wb_data = 32'h0000_0033;
        bus.mdu_valid = 1; bus.mdu_rd = 5'd9; bus.mdu_data = 32'h9999_9999;
        tick();
        bus.mdu_valid = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("starve%0d_addr", i), {27'd0, bus.rf_waddr}, 32'd3);
            chk($sformatf("starve%0d_stall", i), {31'd0, bus.wb_stall_req}, (i == 4) ? 32'd1 : 32'd0);
        end
        bus.wb_valid = 0;
        tick();
        chk("starve_x9_we",   {31'd0, bus.rf_we},        32'd1);
        chk("starve_x9_addr", {27'd0, bus.rf_waddr},     32'd9);
        chk("starve_x9_data", bus.rf_wdata,              32'h9999_9999);
        chk("starve_unstall", {31'd0, bus.wb_stall_req}, 32'd0);
        chk("starve_no_perr", {31'd0, bus.protocol_err}, 32'd0);
        tick();

        // WB rd=0 alongside pending MDU rd=4: MDU granted immediately
        bus.wb_valid = 1; bus.wb_rd = 5'd3; bus.wb_data = 32'h0000_0033;
        bus.mdu_valid = 1; bus.mdu_rd = 5'd4; bus.mdu_data = 32'h4444_4444;
        tick();
        bus.mdu_valid = 0;
        bus.wb_rd = 5'd0; bus.wb_data = 32'hDEAD_0000;
        tick();
        chk("rd0_mdu_we",   {31'd0, bus.rf_we},    32'd1);
        chk("rd0_mdu_addr", {27'd0, bus.rf_waddr}, 32'd4);
        chk("rd0_mdu_data", bus.rf_wdata,          32'h4444_4444);
        bus.wb_valid = 0;
        tick();
        chk("rd0_idle_we", {31'd0, bus.rf_we}, 32'd0);

        // Full FIFO with held MDU result, WB kept asserted through the stall
        pend_rd[0] = 5'd10; pend_data[0] = 32'hA000_000A;
        pend_rd[1] = 5'd11; pend_data[1] = 32'hB000_000B;
        pend_rd[2] = 5'd12; pend_data[2] = 32'hC000_000C;
        cap_rd.delete(); cap_data.delete();
        cap_en = 1'b1;
        idx = 0;
        bus.wb_valid = 1; bus.wb_rd = 5'd3; bus.wb_data = 32'h0000_0033;
        for (int cyc = 0; cyc < 60; cyc++) begin
            logic pushed;
            if (idx < 3) begin
                bus.mdu_valid = 1; bus.mdu_rd = pend_rd[idx]; bus.mdu_data = pend_data[idx];
            end else begin
                bus.mdu_valid = 0;
            end
            #1;
            if (cyc == 2) chk("full_ready_c2", {31'd0, bus.mdu_ready}, 32'd0);
            if (cyc == 4) chk("full_ready_c4", {31'd0, bus.mdu_ready}, 32'd0);
            pushed = bus.mdu_valid && bus.mdu_ready;
            tick();
            if (pushed) idx++;
        end
        bus.mdu_valid = 0;
        chk("full_all_pushed", idx, 32'd3);
        chk("full_wr_count", cap_rd.size(), 32'd3);
        if (cap_rd.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("full_wr%0d_rd", i), {27'd0, cap_rd[i]}, {27'd0, pend_rd[i]});
                chk($sformatf("full_wr%0d_data", i), cap_data[i], pend_data[i]);
            end
        end
        cap_en = 1'b0;
        chk("perr_set", {31'd0, bus.protocol_err}, 32'd1);
        bus.wb_valid = 0;
        repeat (3) tick();
        chk("perr_sticky", {31'd0, bus.protocol_err}, 32'd1);

        // Mid-burst reset with two buffered entries and a busy register
        bus.wb_valid = 1; bus.wb_rd = 5'd3;
        bus.mdu_issue_valid = 1; bus.mdu_issue_rd = 5'd20;
        bus.mdu_valid = 1; bus.mdu_rd = 5'd21; bus.mdu_data = 32'h2121_2121;
        tick();
        bus.mdu_issue_valid = 0;
        bus.mdu_rd = 5'd22; bus.mdu_data = 32'h2222_2222;
        tick();
        bus.mdu_valid = 0;
        bus.rs1 = 5'd20;
        #1;
        chk("pre_rst_haz", {31'd0, bus.hazard_rs1}, 32'd1);
        chk("pre_rst_full", {31'd0, bus.mdu_ready}, 32'd0);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_we",    {31'd0, bus.rf_we},        32'd0);
        chk("mid_rst_ready", {31'd0, bus.mdu_ready},    32'd1);
        chk("mid_rst_perr",  {31'd0, bus.protocol_err}, 32'd0);
        bad = 0;
        for (int r = 0; r < 32; r++) begin
            bus.rs1 = 5'(r);
            #1;
            if (bus.hazard_rs1 !== 1'b0) bad++;
        end
        chk("mid_rst_haz_any", bad, 32'd0);
        bus.wb_valid = 0;
        tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.rf_we !== 1'b0) bad++;
        end
        chk("post_rst_no_write", bad, 32'd0);
        chk("post_rst_ready", {31'd0, bus.mdu_ready}, 32'd1);

        chk("x0_never_written", {31'd0, x0_written}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
